// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: 32-bit machine word and the ALU operation encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/alu_issue_unit.sv
// Issues valid/ready commands to a combinational ALU, captures its result after a
// fixed settle time and returns tagged responses in order through a small FIFO.
module alu_issue_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned RSP_DEPTH     = 2,
    parameter int unsigned TAG_W         = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  aluop_t           cmd_op,
    input  word_t            cmd_a,
    input  word_t            cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output aluop_t           ALUOP,
    output word_t            porta,
    output word_t            portb,
    input  word_t            outport,
    input  logic             neg,
    input  logic             over,
    input  logic             zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output word_t            rsp_result,
    output logic             rsp_neg,
    output logic             rsp_over,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      ops_count
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    typedef struct packed {
        word_t            result;
        logic             neg;
        logic             over;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    state_t           state_q;
    logic             cmd_ready_q;
    aluop_t           op_q;
    word_t            a_q;
    word_t            b_q;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      ops_q;

    rsp_t             mem_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic accept;
    logic push;
    logic pop;
    logic room_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign accept = cmd_valid && cmd_ready_q;
    assign push   = (state_q == SETTLE) && (cnt_q == '0);
    assign pop    = (count_q != '0) && rsp_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // cmd_ready is registered from the post-edge occupancy, so a pop frees the slot next cycle.
    assign room_d = (count_d < CW'(RSP_DEPTH));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            op_q        <= aluop_t'('0);
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            ops_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q        <= cmd_op;
                        a_q         <= cmd_a;
                        b_q         <= cmd_b;
                        tag_q       <= cmd_tag;
                        cnt_q       <= CNT_W'(SETTLE_CYCLES - 1);
                        state_q     <= SETTLE;
                        cmd_ready_q <= 1'b0;
                    end else begin
                        cmd_ready_q <= room_d;
                    end
                end
                SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q     <= IDLE;
                        ops_q       <= ops_q + 16'd1;
                        cmd_ready_q <= room_d;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= '{result: outport, neg: neg, over: over, zero: zero, tag: tag_q};
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            count_q <= count_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = (state_q == SETTLE);
    assign ops_count  = ops_q;
    assign ALUOP      = op_q;
    assign porta      = a_q;
    assign portb      = b_q;
    assign rsp_valid  = (count_q != '0);
    assign rsp_result = mem_q[rd_q].result;
    assign rsp_neg    = mem_q[rd_q].neg;
    assign rsp_over   = mem_q[rd_q].over;
    assign rsp_zero   = mem_q[rd_q].zero;
    assign rsp_tag    = mem_q[rd_q].tag;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a second instance with a longer settle.
module tb_alu_issue_unit;
    import cpu_types_pkg::*;

    localparam int DEPTH  = 2;
    localparam int SETTLE = 1;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Main DUT (SETTLE_CYCLES=1)
    logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    aluop_t cmd_op, ALUOP;
    word_t cmd_a, cmd_b, porta, portb, outport, rsp_result;
    logic neg, over, zero, rsp_neg, rsp_over, rsp_zero;
    logic [3:0] cmd_tag, rsp_tag;
    logic [15:0] ops_count;

    // Second DUT (SETTLE_CYCLES=3)
    logic s3_cmd_valid, s3_cmd_ready, s3_rsp_valid, s3_rsp_ready, s3_busy;
    aluop_t s3_cmd_op, s3_ALUOP;
    word_t s3_cmd_a, s3_cmd_b, s3_porta, s3_portb, s3_outport, s3_rsp_result;
    logic s3_neg, s3_over, s3_zero, s3_rsp_neg, s3_rsp_over, s3_rsp_zero;
    logic [3:0] s3_cmd_tag, s3_rsp_tag;
    logic [15:0] s3_ops_count;

    alu_issue_unit #(.SETTLE_CYCLES(SETTLE), .RSP_DEPTH(DEPTH), .TAG_W(4)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .ALUOP(ALUOP), .porta(porta), .portb(portb),
        .outport(outport), .neg(neg), .over(over), .zero(zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_neg(rsp_neg), .rsp_over(rsp_over), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .busy(busy), .ops_count(ops_count)
    );

    alu_issue_unit #(.SETTLE_CYCLES(3), .RSP_DEPTH(2), .TAG_W(4)) u_s3 (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready), .cmd_op(s3_cmd_op),
        .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b), .cmd_tag(s3_cmd_tag),
        .ALUOP(s3_ALUOP), .porta(s3_porta), .portb(s3_portb),
        .outport(s3_outport), .neg(s3_neg), .over(s3_over), .zero(s3_zero),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_result(s3_rsp_result),
        .rsp_neg(s3_rsp_neg), .rsp_over(s3_rsp_over), .rsp_zero(s3_rsp_zero), .rsp_tag(s3_rsp_tag),
        .busy(s3_busy), .ops_count(s3_ops_count)
    );

    function automatic word_t alu_r(input aluop_t op, input word_t a, input word_t b);
        case (op)
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic alu_v(input aluop_t op, input word_t a, input word_t b);
        word_t r;
        r = alu_r(op, a, b);
        if (op == ALU_ADD) return (a[31] == b[31]) && (r[31] != a[31]);
        if (op == ALU_SUB) return (a[31] != b[31]) && (r[31] != a[31]);
        return 1'b0;
    endfunction

    // Combinational ALU stand-ins
    always_comb begin
        outport = alu_r(ALUOP, porta, portb);
        neg     = outport[31];
        zero    = (outport == 32'd0);
        over    = alu_v(ALUOP, porta, portb);
    end

    always_comb begin
        s3_outport = alu_r(s3_ALUOP, s3_porta, s3_portb);
        s3_neg     = s3_outport[31];
        s3_zero    = (s3_outport == 32'd0);
        s3_over    = alu_v(s3_ALUOP, s3_porta, s3_portb);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one op in flight with a cycle countdown, plus a response queue.
    typedef struct {
        word_t      r;
        logic       n;
        logic       o;
        logic       z;
        logic [3:0] t;
    } exp_rsp_t;

    exp_rsp_t    mq[$];
    bit          m_busy;
    int          m_rem;
    aluop_t      m_op;
    word_t       m_a, m_b;
    logic [3:0]  m_tag;
    logic [15:0] m_ops;
    bit          m_started;

    function automatic bit exp_ready();
        return m_started && !m_busy && (mq.size() < DEPTH);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mq.delete();
            m_busy    = 0;
            m_rem     = 0;
            m_op      = ALU_SLL;
            m_a       = 0;
            m_b       = 0;
            m_tag     = 0;
            m_ops     = 0;
            m_started = 0;
        end else begin
            bit acc, popm;
            exp_rsp_t e;
            acc  = cmd_valid && exp_ready();
            popm = rsp_ready && (mq.size() != 0);
            if (popm) void'(mq.pop_front());
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    e.r = alu_r(m_op, m_a, m_b);
                    e.n = e.r[31];
                    e.o = alu_v(m_op, m_a, m_b);
                    e.z = (e.r == 32'd0);
                    e.t = m_tag;
                    mq.push_back(e);
                    m_busy = 0;
                    m_ops++;
                end
            end
            if (acc) begin
                m_op   = cmd_op;
                m_a    = cmd_a;
                m_b    = cmd_b;
                m_tag  = cmd_tag;
                m_busy = 1;
                m_rem  = SETTLE;
            end
            m_started = 1;
        end
    end

    always @(negedge CLK) begin
        if (nRST) begin
            check("cmd_ready", 64'(cmd_ready), 64'(exp_ready()));
            check("busy", 64'(busy), 64'(m_busy));
            check("rsp_valid", 64'(rsp_valid), 64'(mq.size() != 0));
            check("ALUOP", 64'(ALUOP), 64'(m_op));
            check("porta", 64'(porta), 64'(m_a));
            check("portb", 64'(portb), 64'(m_b));
            check("ops_count", 64'(ops_count), 64'(m_ops));
            if (mq.size() != 0) begin
                check("rsp_result", 64'(rsp_result), 64'(mq[0].r));
                check("rsp_flags", 64'({rsp_neg, rsp_over, rsp_zero}),
                      64'({mq[0].n, mq[0].o, mq[0].z}));
                check("rsp_tag", 64'(rsp_tag), 64'(mq[0].t));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input aluop_t op, input word_t a, input word_t b, input logic [3:0] tag);
        bit rdy;
        rdy       = 0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            rdy = cmd_ready;
            tick();
            if (rdy) break;
        end
        cmd_valid = 1'b0;
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got no accept, required accept within 50 cycles (tag %0h)", tag);
        end
    endtask

    task automatic expect_head(input word_t r, input logic n, input logic o, input logic z,
                               input logic [3:0] t);
        check("head_valid", 64'(rsp_valid), 64'(1));
        check("head_result", 64'(rsp_result), 64'(r));
        check("head_flags", 64'({rsp_neg, rsp_over, rsp_zero}), 64'({n, o, z}));
        check("head_tag", 64'(rsp_tag), 64'(t));
    endtask

    function automatic word_t pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return word_t'($urandom_range(0, 31));
            default: return word_t'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 0; cmd_op = ALU_SLL; cmd_a = 0; cmd_b = 0; cmd_tag = 0; rsp_ready = 0;
        s3_cmd_valid = 0; s3_cmd_op = ALU_SLL; s3_cmd_a = 0; s3_cmd_b = 0; s3_cmd_tag = 0;
        s3_rsp_ready = 0;

        // Reset state
        #3;
        check("rst_ALUOP", 64'(ALUOP), 64'(0));
        check("rst_porta", 64'(porta), 64'(0));
        check("rst_portb", 64'(portb), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ops", 64'(ops_count), 64'(0));
        check("rst_rsp_data", 64'({rsp_result, rsp_neg, rsp_over, rsp_zero, rsp_tag}), 64'(0));
        @(posedge CLK);
        #2 nRST = 1'b1;
        tick();
        check("ready_after_rst", 64'(cmd_ready), 64'(1));

        // Longer settle: drive at E0, capture at E0+3, ready again for E0+4
        check("s3_ready", 64'(s3_cmd_ready), 64'(1));
        s3_cmd_op = ALU_ADD; s3_cmd_a = 32'd10; s3_cmd_b = 32'd20; s3_cmd_tag = 4'd5;
        s3_cmd_valid = 1'b1;
        tick();
        s3_cmd_valid = 1'b0;
        check("s3_E0_ALUOP", 64'(s3_ALUOP), 64'(ALU_ADD));
        check("s3_E0_porta", 64'(s3_porta), 64'(10));
        check("s3_E0_portb", 64'(s3_portb), 64'(20));
        check("s3_E0_busy", 64'(s3_busy), 64'(1));
        check("s3_E0_valid", 64'(s3_rsp_valid), 64'(0));
        tick();
        check("s3_E1_busy", 64'(s3_busy), 64'(1));
        check("s3_E1_valid", 64'(s3_rsp_valid), 64'(0));
        check("s3_E1_ready", 64'(s3_cmd_ready), 64'(0));
        tick();
        check("s3_E2_busy", 64'(s3_busy), 64'(1));
        check("s3_E2_valid", 64'(s3_rsp_valid), 64'(0));
        tick();
        check("s3_E3_busy", 64'(s3_busy), 64'(0));
        check("s3_E3_valid", 64'(s3_rsp_valid), 64'(1));
        check("s3_E3_result", 64'(s3_rsp_result), 64'(30));
        check("s3_E3_tag", 64'(s3_rsp_tag), 64'(5));
        check("s3_E3_ops", 64'(s3_ops_count), 64'(1));
        check("s3_E3_ready", 64'(s3_cmd_ready), 64'(1));

        // ADD 5+7, response one edge after accept
        cmd_op = ALU_ADD; cmd_a = 32'd5; cmd_b = 32'd7; cmd_tag = 4'd3;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t1_porta", 64'(porta), 64'(5));
        check("t1_portb", 64'(portb), 64'(7));
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_valid_early", 64'(rsp_valid), 64'(0));
        tick();
        expect_head(32'd12, 1'b0, 1'b0, 1'b0, 4'd3);
        check("t1_ops", 64'(ops_count), 64'(1));

        // Zero flag and signed overflow
        issue(ALU_SUB, 32'h1234, 32'h1234, 4'd4);
        tick();
        expect_head(32'd0, 1'b0, 1'b0, 1'b1, 4'd4);
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'd5);
        tick();
        expect_head(32'h8000_0000, 1'b1, 1'b1, 1'b0, 4'd5);

        // Backpressure: two entries fill the FIFO, third waits for a pop
        tick();
        rsp_ready = 1'b0;
        check("t3_empty", 64'(rsp_valid), 64'(0));
        issue(ALU_ADD, 32'd1, 32'd1, 4'd1);
        tick();
        issue(ALU_ADD, 32'd2, 32'd2, 4'd2);
        tick();
        cmd_op = ALU_ADD; cmd_a = 32'd3; cmd_b = 32'd3; cmd_tag = 4'd3; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t3_held_ready", 64'(cmd_ready), 64'(0));
            check("t3_held_busy", 64'(busy), 64'(0));
            tick();
        end
        cmd_valid = 1'b0;
        expect_head(32'd2, 1'b0, 1'b0, 1'b0, 4'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t3_ready_after_pop", 64'(cmd_ready), 64'(1));
        expect_head(32'd4, 1'b0, 1'b0, 1'b0, 4'd2);
        issue(ALU_ADD, 32'd3, 32'd3, 4'd3);
        tick();
        rsp_ready = 1'b1;
        expect_head(32'd4, 1'b0, 1'b0, 1'b0, 4'd2);
        tick();
        expect_head(32'd6, 1'b0, 1'b0, 1'b0, 4'd3);
        tick();
        check("t3_drained", 64'(rsp_valid), 64'(0));

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = aluop_t'(4'($urandom_range(0, 9)));
            cmd_a     = pick();
            cmd_b     = ($urandom_range(0, 7) == 0) ? cmd_a : pick();
            cmd_tag   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 4) > 1);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) tick();
        check("rand_drained", 64'(rsp_valid), 64'(0));

        // Asynchronous reset mid-SETTLE with one FIFO entry
        rsp_ready = 1'b0;
        issue(ALU_ADD, 32'd10, 32'd1, 4'd7);
        tick();
        issue(ALU_SUB, 32'd10, 32'd1, 4'd8);
        check("t5_in_settle", 64'(busy), 64'(1));
        #2 nRST = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_cmd_ready", 64'(cmd_ready), 64'(0));
        check("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        check("t5_ALUOP", 64'(ALUOP), 64'(0));
        check("t5_ports", 64'({porta, portb}), 64'(0));
        check("t5_ops", 64'(ops_count), 64'(0));
        check("t5_rsp_data", 64'({rsp_result, rsp_neg, rsp_over, rsp_zero, rsp_tag}), 64'(0));
        check("t5_s3_valid", 64'(s3_rsp_valid), 64'(0));
        check("t5_s3_porta", 64'(s3_porta), 64'(0));
        @(posedge CLK);
        #2 nRST = 1'b1;
        tick();
        rsp_ready = 1'b1;
        issue(ALU_ADD, 32'd1, 32'd2, 4'd9);
        tick();
        expect_head(32'd3, 1'b0, 1'b0, 1'b0, 4'd9);
        check("t5_ops_restart", 64'(ops_count), 64'(1));

        // ops_count wrap
        force u_dut.ops_q = 16'hFFFE;
        m_ops = 16'hFFFE;
        #1 release u_dut.ops_q;
        issue(ALU_OR, 32'd0, 32'd0, 4'd1);
        tick();
        check("t6_ops_ffff", 64'(ops_count), 64'(16'hFFFF));
        expect_head(32'd0, 1'b0, 1'b0, 1'b1, 4'd1);
        issue(ALU_XOR, 32'hF0, 32'h0F, 4'd2);
        tick();
        check("t6_ops_wrap", 64'(ops_count), 64'(0));
        expect_head(32'hFF, 1'b0, 1'b0, 1'b0, 4'd2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
